// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
//   ex_state_t : execute-stage status reported on ex_status
//   ALU_*      : ULAcontrol encodings understood by mips_alu
//   FWD_*      : operand forwarding selects
package mips_pkg;

  typedef enum logic [1:0] {
    EX_NORMAL = 2'd0,
    EX_STALL  = 2'd1,
    EX_FLUSH  = 2'd2,
    EX_ERROR  = 2'd3
  } ex_state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Anything outside the five implemented encodings is illegal.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return !(op == ALU_AND || op == ALU_OR || op == ALU_ADD ||
             op == ALU_SUB || op == ALU_SLT);
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the execute stage.
//   a, b     : operands
//   op       : ULAcontrol encoding (see mips_pkg)
//   result   : operation result (0 for illegal ops)
//   zero     : result == 0
//   overflow : signed overflow of ADD/SUB, 0 otherwise
//   illegal  : op is not an implemented encoding
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              a_lt_b;

  assign sum    = a + b;
  assign diff   = a - b;
  assign a_lt_b = $signed(a) < $signed(b);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        // Same-sign operands producing a differently signed sum.
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff;
        // Opposite-sign operands where the difference takes b's sign.
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, a_lt_b};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register.
//   clk, reset           : clock, asynchronous active-high reset
//   stall, flush         : hold / bubble-insert control for EX/MEM
//   *_in                 : ID/EX data and control for the EX instruction
//   forward_a/b, wb_result : MEM/WB forwarding selects and write-back value
//   branch_taken/target  : combinational beq redirect to fetch
//   *_out                : registered EX/MEM contents for the MEM stage
//   ex_status, error_flag: stage status and sticky illegal-op flag
//   stall/flush/branch_count : free-running wrapping event counters
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic [DATA_W-1:0] reg_data1_in,
  input  logic [DATA_W-1:0] reg_data2_in,
  input  logic [DATA_W-1:0] signimm_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic              regwrite_in,
  input  logic              memtoreg_in,
  input  logic              memwrite_in,
  input  logic              memread_in,
  input  logic              ULAsrc_in,
  input  logic              regdst_in,
  input  logic              branch_in,
  input  logic [2:0]        ULAcontrol_in,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] wb_result,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_W-1:0]  write_reg_out,
  output logic              regwrite_out,
  output logic              memtoreg_out,
  output logic              memwrite_out,
  output logic              memread_out,
  output logic              valid_out,
  output logic              overflow_out,
  output logic [1:0]        ex_status,
  output logic              error_flag,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count,
  output logic [CNT_W-1:0]  branch_count
);

  // ---------------- Forwarding ----------------
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;

  always_comb begin
    op_a = reg_data1_in;
    case (forward_a)
      FWD_MEM: op_a = alu_result_out;
      FWD_WB:  op_a = wb_result;
      default: op_a = reg_data1_in;
    endcase
  end

  always_comb begin
    fwd_b = reg_data2_in;
    case (forward_b)
      FWD_MEM: fwd_b = alu_result_out;
      FWD_WB:  fwd_b = wb_result;
      default: fwd_b = reg_data2_in;
    endcase
  end

  assign op_b = ULAsrc_in ? signimm_in : fwd_b;

  // ---------------- ALU ----------------
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_overflow;
  logic              alu_illegal;

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (ULAcontrol_in),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow),
    .illegal  (alu_illegal)
  );

  // beq compares the forwarded register values, not the ALU operand B,
  // so zero from the ALU is not the branch condition here.
  logic alu_zero_unused;
  assign alu_zero_unused = alu_zero;

  // ---------------- Branch resolution ----------------
  assign branch_taken  = valid_in & branch_in & (op_a == fwd_b) & ~stall & ~flush;
  assign branch_target = pc_plus4_in + {signimm_in[DATA_W-3:0], 2'b00};

  // ---------------- EX/MEM register ----------------
  logic              capture;
  logic              error_set;
  logic [REG_W-1:0]  write_reg;

  assign capture   = ~flush & ~stall;
  assign error_set = valid_in & alu_illegal & capture;
  assign write_reg = regdst_in ? rd_in : rt_in;

  logic [DATA_W-1:0] alu_result_reg;
  logic [DATA_W-1:0] write_data_reg;
  logic [REG_W-1:0]  write_reg_reg;
  logic              regwrite_reg;
  logic              memtoreg_reg;
  logic              memwrite_reg;
  logic              memread_reg;
  logic              valid_reg;
  logic              overflow_reg;
  logic              error_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_reg <= '0;
      write_data_reg <= '0;
      write_reg_reg  <= '0;
      regwrite_reg   <= 1'b0;
      memtoreg_reg   <= 1'b0;
      memwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      valid_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (flush) begin
      alu_result_reg <= '0;
      write_data_reg <= '0;
      write_reg_reg  <= '0;
      regwrite_reg   <= 1'b0;
      memtoreg_reg   <= 1'b0;
      memwrite_reg   <= 1'b0;
      memread_reg    <= 1'b0;
      valid_reg      <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (!stall) begin
      alu_result_reg <= alu_result;
      write_data_reg <= fwd_b;
      write_reg_reg  <= write_reg;
      // Illegal ops must never modify architectural state downstream.
      regwrite_reg   <= regwrite_in & valid_in & ~alu_illegal;
      memtoreg_reg   <= memtoreg_in & valid_in;
      memwrite_reg   <= memwrite_in & valid_in & ~alu_illegal;
      memread_reg    <= memread_in & valid_in;
      valid_reg      <= valid_in;
      overflow_reg   <= alu_overflow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else if (error_set) begin
      error_reg <= 1'b1;
    end
  end

  assign alu_result_out = alu_result_reg;
  assign write_data_out = write_data_reg;
  assign write_reg_out  = write_reg_reg;
  assign regwrite_out   = regwrite_reg;
  assign memtoreg_out   = memtoreg_reg;
  assign memwrite_out   = memwrite_reg;
  assign memread_out    = memread_reg;
  assign valid_out      = valid_reg;
  assign overflow_out   = overflow_reg;
  assign error_flag     = error_reg;

  // ---------------- Status FSM ----------------
  ex_state_t state_reg;
  ex_state_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= EX_NORMAL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = EX_NORMAL;
    if (state_reg == EX_ERROR || error_reg || error_set) begin
      state_next = EX_ERROR;
    end else if (flush) begin
      state_next = EX_FLUSH;
    end else if (stall) begin
      state_next = EX_STALL;
    end
  end

  assign ex_status = state_reg;

  // ---------------- Event counters ----------------
  // Index 0: stall, 1: flush, 2: taken branch.
  logic [2:0]         cnt_inc;
  logic [3*CNT_W-1:0] cnt_bus;

  assign cnt_inc = {branch_taken, flush, stall};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_bus[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

  assign stall_count  = cnt_bus[0*CNT_W +: CNT_W];
  assign flush_count  = cnt_bus[1*CNT_W +: CNT_W];
  assign branch_count = cnt_bus[2*CNT_W +: CNT_W];

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline; sits directly downstream of the ID/EX register and consumes its data and control outputs.
- Applies MEM/WB forwarding to both operands, performs the ALU operation, resolves beq, and registers results for the MEM stage.
- Provides branch redirect to fetch, pipeline status, sticky illegal-op error and performance counters.

Parameters:
- DATA_W, 32, datapath width
- REG_W, 5, register-address width
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold EX/MEM contents
- flush  in  1  synchronous bubble insert into EX/MEM
- valid_in  in  1  ID/EX holds a real instruction
- pc_plus4_in  in  DATA_W  PC+4 of the EX instruction
- reg_data1_in, reg_data2_in  in  DATA_W  register operands
- signimm_in  in  DATA_W  sign-extended immediate
- rt_in, rd_in  in  REG_W  destination candidates
- regwrite_in, memtoreg_in, memwrite_in, memread_in, ULAsrc_in, regdst_in, branch_in  in  1 each  control
- ULAcontrol_in  in  3  ALU op
- forward_a, forward_b  in  2  00 register, 10 MEM alu_result_out, 01 wb_result; 11 treated as 00
- wb_result  in  DATA_W  write-back value
- branch_taken  out  1  combinational redirect
- branch_target  out  DATA_W  pc_plus4_in + (signimm_in << 2), combinational
- alu_result_out, write_data_out  out  DATA_W  registered
- write_reg_out  out  REG_W  registered
- regwrite_out, memtoreg_out, memwrite_out, memread_out, valid_out, overflow_out  out  1 each  registered
- ex_status  out  2  ex_state_t
- error_flag  out  1  sticky illegal-op
- stall_count, flush_count, branch_count  out  CNT_W  counters

Behaviour:
- Reset: every registered output, ex_status = EX_NORMAL, error_flag and all counters cleared to 0.
- Operand A: forward_a mux output. Operand B: the forward_b mux output, replaced by signimm_in when ULAsrc_in = 1. write_data_out captures the forward_b mux output, never signimm_in.
- ALU ops:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed; result 1 or 0).
  - ADD/SUB wrap modulo 2^DATA_W.
  - overflow = signed overflow on ADD/SUB, 0 for other ops.
  - 011/100/101 are illegal: result 0, regwrite and memwrite suppressed, error_flag set when valid_in is high and the register updates. error_flag stays set until reset.
- write_reg = regdst_in ? rd_in : rt_in.
- branch_taken = valid_in & branch_in & (A == B_forwarded) & !stall & !flush, same cycle. branch_target is always driven.
- Register priority:
  - reset: clear everything.
  - flush: all EX/MEM outputs go to 0, including valid_out and control.
  - stall: hold all outputs.
  - otherwise capture. Controls are ANDed with valid_in.
- Latency: 1 cycle from ID/EX outputs to EX/MEM outputs.
- State machine ex_state_t, next state evaluated each clock:
  - error_flag set or being set -> EX_ERROR (absorbing until reset).
  - else flush -> EX_FLUSH.
  - else stall -> EX_STALL.
  - else EX_NORMAL.
- Counters wrap at 2^CNT_W:
  - stall_count increments in any cycle with stall, including when flush is also asserted.
  - flush_count increments on flush.
  - branch_count increments when branch_taken is high.
- Reset mid-stall or mid-flush: reset wins asynchronously. The first clock after deassertion captures normally.

Decomposition:
- Shared package mips_pkg: ex_state_t {EX_NORMAL = 0, EX_STALL = 1, EX_FLUSH = 2, EX_ERROR = 3}, ALU op constants, forward-select constants.
- One sub-module, mips_alu: combinational; inputs a, b, op; outputs result, zero, overflow, illegal.

Test Plan:
- A = 5, B = 7, op 010, regdst = 1, rd = 3, regwrite = 1, valid_in = 1 -> next cycle alu_result_out = 12, write_reg_out = 3, regwrite_out = 1.
- Forwarding: forward_a = 10 with MEM alu_result_out = 12; forward_b = 01 with wb_result = 20; op 110 -> alu_result_out = 0xFFFFFFF8. Then A = 0x7FFFFFFF, B = 1, op 010 -> overflow_out = 1.
- beq with A = B = 9, pc_plus4 = 0x100, signimm = 4 -> branch_taken = 1 and branch_target = 0x110 in the same cycle; branch_count = 1.
- Hold stall 3 cycles, then assert flush together with stall -> outputs held during the stall, then all 0; stall_count = 4, flush_count = 1; ex_status moves through EX_STALL to EX_FLUSH.
- op 011 with valid_in = 1, regwrite = 1 -> regwrite_out = 0, error_flag = 1, ex_status = EX_ERROR, persisting through later legal ops until reset.
- Assert reset asynchronously mid-stall -> all outputs and counters read 0 before the next clock edge.
